cursor_input_cond: RTL



---
 rtl/cursor_input_cond.sv | 106 ++++++++++
 1 files changed

// File: rtl/cursor_input_cond.sv
// cursor_input_cond: synchronizes and debounces the push-buttons, then turns
// size/mode presses into single-cycle selection pulses for the cursor overlay.
module cursor_input_cond #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_move_n,
    input  logic       key_size_n,
    input  logic       key_mode_n,
    output logic [3:0] move,
    output logic [3:0] size,
    output logic [1:0] mode,
    output logic [1:0] size_idx,
    output logic       mode_state
);
    typedef enum logic [1:0] {OFF, S320, S240, S120} size_t;
    logic [5:0] s1, s2, db;
    logic [1:0] db_d, press;
    logic       sync_pend, pend_s, pend_m, pend_s_nx, pend_m_nx, ev_s, ev_m;
    logic       ms, ms_nx;
    logic [3:0] size_nx;
    logic [1:0] mode_nx;
    size_t      st, st_nx;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= {key_mode_n, key_size_n, key_move_n};
            s2 <= s1;
        end
    end
    // any cycle where the input agrees with the accepted state restarts the count
    for (genvar i = 0; i < 6; i++) begin : g_deb
        logic             db_r;
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                db_r <= 1'b1;
                cnt  <= '0;
            end else if (s2[i] == db_r) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_r <= s2[i];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign db[i] = db_r;
    end
    assign press = db_d & ~db[5:4];
    assign ev_s  = press[0] | pend_s;
    assign ev_m  = press[1] | pend_m;
    // a press landing on the sync cycle is parked and replayed one cycle later
    always_comb begin
        st_nx     = st;
        ms_nx     = ms;
        size_nx   = 4'b0000;
        mode_nx   = 2'b00;
        pend_s_nx = 1'b0;
        pend_m_nx = 1'b0;
        if (sync_pend) begin
            size_nx   = 4'b0001;
            mode_nx   = 2'b01;
            pend_s_nx = press[0];
            pend_m_nx = press[1];
        end else begin
            if (ev_s) begin
                st_nx   = size_t'(st + 2'd1);
                size_nx = 4'b0001 << st_nx;
            end
            if (ev_m) begin
                ms_nx   = ~ms;
                mode_nx = ms ? 2'b01 : 2'b10;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= OFF;
            ms        <= 1'b0;
            size      <= 4'b0000;
            mode      <= 2'b00;
            move      <= 4'b1111;
            db_d      <= 2'b11;
            sync_pend <= 1'b1;
            pend_s    <= 1'b0;
            pend_m    <= 1'b0;
        end else begin
            st        <= st_nx;
            ms        <= ms_nx;
            size      <= size_nx;
            mode      <= mode_nx;
            move      <= db[3:0];
            db_d      <= db[5:4];
            sync_pend <= 1'b0;
            pend_s    <= pend_s_nx;
            pend_m    <= pend_m_nx;
        end
    end
    assign size_idx   = st;
    assign mode_state = ms;
endmodule
